// File: rtl/regfile_writeback_pkg.sv
// rtl/regfile_writeback_pkg.sv - shared types and widths for the register-file writeback stage
package regfile_writeback_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        KIND_ALU       = 2'b00,
        KIND_LOAD      = 2'b01,
        KIND_ADDR      = 2'b10,
        KIND_LOAD_ADDR = 2'b11
    } wb_kind_e;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/regfile_writeback_forward_mux.sv
// rtl/regfile_writeback_forward_mux.sv - one decode forwarding port matched against both write ports
module wb_forward_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] query,
    input  logic              wen0,
    input  logic [REG_AW-1:0] waddr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              wen1,
    input  logic [REG_AW-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              hit,
    output logic [DATA_W-1:0] data
);

    logic nonzero;
    logic hit0;
    logic hit1;

    // r0 is hardwired, so a zero query never forwards even if a port shows address 0
    assign nonzero = (query != '0);
    assign hit0    = nonzero && wen0 && (waddr0 == query);
    assign hit1    = nonzero && wen1 && (waddr1 == query);
    assign hit     = hit0 || hit1;

    always_comb begin
        data = '0;
        if (hit0) begin
            data = wdata0;
        end else if (hit1) begin
            data = wdata1;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - writeback stage driving both register-file write ports with forwarding
module regfile_writeback #(
    parameter int DATA_W = regfile_writeback_pkg::DATA_W,
    parameter int REG_AW = regfile_writeback_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [DATA_W-1:0] in_result,
    input  logic [REG_AW-1:0] in_ra,
    input  logic [DATA_W-1:0] in_addr,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wen0,
    output logic [REG_AW-1:0] waddr0,
    output logic [DATA_W-1:0] wdata0,
    output logic              wen1,
    output logic [REG_AW-1:0] waddr1,
    output logic [DATA_W-1:0] wdata1,
    input  logic [REG_AW-1:0] fwd_addr0,
    input  logic [REG_AW-1:0] fwd_addr1,
    output logic              fwd_hit0,
    output logic              fwd_hit1,
    output logic [DATA_W-1:0] fwd_data0,
    output logic [DATA_W-1:0] fwd_data1,
    output logic              err_spurious
);

    import regfile_writeback_pkg::*;

    wb_state_e         state, next_state;
    wb_kind_e          kind_q;
    logic [REG_AW-1:0] rd_q;
    logic [REG_AW-1:0] ra_q;
    logic [DATA_W-1:0] addr_q;
    logic              accept_load;

    logic              nx_wen0, nx_wen1;
    logic [REG_AW-1:0] nx_waddr0, nx_waddr1;
    logic [DATA_W-1:0] nx_wdata0, nx_wdata1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= WB_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        in_ready    = 1'b0;
        accept_load = 1'b0;
        nx_wen0     = 1'b0;
        nx_waddr0   = '0;
        nx_wdata0   = '0;
        nx_wen1     = 1'b0;
        nx_waddr1   = '0;
        nx_wdata1   = '0;
        case (state)
            WB_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    case (wb_kind_e'(in_kind))
                        KIND_ALU: begin
                            nx_wen0   = 1'b1;
                            nx_waddr0 = in_rd;
                            nx_wdata0 = in_result;
                        end
                        KIND_ADDR: begin
                            nx_wen1   = 1'b1;
                            nx_waddr1 = in_ra;
                            nx_wdata1 = in_addr;
                        end
                        default: begin
                            accept_load = 1'b1;
                            next_state  = WB_WAIT;
                        end
                    endcase
                end
            end
            WB_WAIT: begin
                // address update rides with its load data so it can never land first
                if (mem_rvalid) begin
                    nx_wen0    = 1'b1;
                    nx_waddr0  = rd_q;
                    nx_wdata0  = mem_rdata;
                    nx_wen1    = (kind_q == KIND_LOAD_ADDR);
                    nx_waddr1  = ra_q;
                    nx_wdata1  = addr_q;
                    next_state = WB_IDLE;
                end
            end
            default: next_state = WB_IDLE;
        endcase
        if (nx_waddr0 == '0) nx_wen0 = 1'b0;
        if (nx_waddr1 == '0) nx_wen1 = 1'b0;
        // same-register collision: load data wins over the address update
        if (nx_wen0 && nx_wen1 && (nx_waddr0 == nx_waddr1)) nx_wen1 = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            kind_q <= KIND_ALU;
            rd_q   <= '0;
            ra_q   <= '0;
            addr_q <= '0;
        end else if (accept_load) begin
            kind_q <= wb_kind_e'(in_kind);
            rd_q   <= in_rd;
            ra_q   <= in_ra;
            addr_q <= in_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wen0   <= 1'b0;
            waddr0 <= '0;
            wdata0 <= '0;
            wen1   <= 1'b0;
            waddr1 <= '0;
            wdata1 <= '0;
        end else begin
            wen0   <= nx_wen0;
            waddr0 <= nx_waddr0;
            wdata0 <= nx_wdata0;
            wen1   <= nx_wen1;
            waddr1 <= nx_waddr1;
            wdata1 <= nx_wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_spurious <= 1'b0;
        end else if (mem_rvalid && (state == WB_IDLE)) begin
            err_spurious <= 1'b1;
        end
    end

    wb_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd0 (
        .query  (fwd_addr0),
        .wen0   (wen0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .wen1   (wen1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .hit    (fwd_hit0),
        .data   (fwd_data0)
    );

    wb_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
        .query  (fwd_addr1),
        .wen0   (wen0),
        .waddr0 (waddr0),
        .wdata0 (wdata0),
        .wen1   (wen1),
        .waddr1 (waddr1),
        .wdata1 (wdata1),
        .hit    (fwd_hit1),
        .data   (fwd_data1)
    );

endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - directed and randomized checks of regfile_writeback against a reference model
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd;
    logic [31:0] in_result;
    logic [4:0]  in_ra;
    logic [31:0] in_addr;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wen0, wen1;
    logic [4:0]  waddr0, waddr1;
    logic [31:0] wdata0, wdata1;
    logic [4:0]  fwd_addr0, fwd_addr1;
    logic        fwd_hit0, fwd_hit1;
    logic [31:0] fwd_data0, fwd_data1;
    logic        err_spurious;

    always #5 clk = ~clk;

    regfile_writeback dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_kind      (in_kind),
        .in_rd        (in_rd),
        .in_result    (in_result),
        .in_ra        (in_ra),
        .in_addr      (in_addr),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wen0         (wen0),
        .waddr0       (waddr0),
        .wdata0       (wdata0),
        .wen1         (wen1),
        .waddr1       (waddr1),
        .wdata1       (wdata1),
        .fwd_addr0    (fwd_addr0),
        .fwd_addr1    (fwd_addr1),
        .fwd_hit0     (fwd_hit0),
        .fwd_hit1     (fwd_hit1),
        .fwd_data0    (fwd_data0),
        .fwd_data1    (fwd_data1),
        .err_spurious (err_spurious)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // reference model: one outstanding load at most, sticky error
    bit          m_pend;
    int          m_kind;
    logic [4:0]  m_rd, m_ra;
    logic [31:0] m_addr;
    bit          m_err;
    bit          e_wen0, e_wen1, e_reset;
    logic [4:0]  e_waddr0, e_waddr1;
    logic [31:0] e_wdata0, e_wdata1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit v, input int kind, input int rd, input logic [31:0] result,
                         input int ra, input logic [31:0] addr, input bit rv, input logic [31:0] rdata);
        in_valid   = v;
        in_kind    = 2'(kind);
        in_rd      = 5'(rd);
        in_result  = result;
        in_ra      = 5'(ra);
        in_addr    = addr;
        mem_rvalid = rv;
        mem_rdata  = rdata;
    endtask

    function automatic void expect_fwd(input logic [4:0] q, output bit hit, output logic [31:0] data);
        hit  = 1'b0;
        data = 32'h0;
        if (q != 0 && e_wen0 && e_waddr0 == q) begin
            hit = 1'b1; data = e_wdata0;
        end else if (q != 0 && e_wen1 && e_waddr1 == q) begin
            hit = 1'b1; data = e_wdata1;
        end
    endfunction

    // applies current inputs for one clock and checks everything the edge produced
    task automatic cycle();
        bit          h;
        logic [31:0] d;
        check_eq("in_ready_pre", {31'b0, in_ready}, {31'b0, rst_n ? !m_pend : in_ready});
        e_wen0 = 0; e_wen1 = 0; e_waddr0 = 0; e_waddr1 = 0; e_wdata0 = 0; e_wdata1 = 0;
        e_reset = !rst_n;
        if (!rst_n) begin
            m_pend = 0;
            m_err  = 0;
        end else if (!m_pend) begin
            if (mem_rvalid) m_err = 1;
            if (in_valid) begin
                if (in_kind == 2'd0) begin
                    e_wen0 = 1; e_waddr0 = in_rd; e_wdata0 = in_result;
                end else if (in_kind == 2'd2) begin
                    e_wen1 = 1; e_waddr1 = in_ra; e_wdata1 = in_addr;
                end else begin
                    m_pend = 1; m_kind = int'(in_kind); m_rd = in_rd; m_ra = in_ra; m_addr = in_addr;
                end
            end
        end else if (mem_rvalid) begin
            e_wen0 = 1; e_waddr0 = m_rd; e_wdata0 = mem_rdata;
            if (m_kind == 3) begin
                e_wen1 = 1; e_waddr1 = m_ra; e_wdata1 = m_addr;
            end
            m_pend = 0;
        end
        if (e_waddr0 == 0) e_wen0 = 0;
        if (e_waddr1 == 0) e_wen1 = 0;
        if (e_wen0 && e_wen1 && e_waddr0 == e_waddr1) e_wen1 = 0;

        @(posedge clk);
        #1;
        check_eq("wen0", {31'b0, wen0}, {31'b0, e_wen0});
        check_eq("wen1", {31'b0, wen1}, {31'b0, e_wen1});
        if (e_wen0 || e_reset) begin
            check_eq("waddr0", {27'b0, waddr0}, {27'b0, e_waddr0});
            check_eq("wdata0", wdata0, e_wdata0);
        end
        if (e_wen1 || e_reset) begin
            check_eq("waddr1", {27'b0, waddr1}, {27'b0, e_waddr1});
            check_eq("wdata1", wdata1, e_wdata1);
        end
        check_eq("err_spurious", {31'b0, err_spurious}, {31'b0, m_err});
        check_eq("in_ready_post", {31'b0, in_ready}, {31'b0, !m_pend});
        expect_fwd(fwd_addr0, h, d);
        check_eq("fwd_hit0", {31'b0, fwd_hit0}, {31'b0, h});
        check_eq("fwd_data0", fwd_data0, d);
        expect_fwd(fwd_addr1, h, d);
        check_eq("fwd_hit1", {31'b0, fwd_hit1}, {31'b0, h});
        check_eq("fwd_data1", fwd_data1, d);
    endtask

    task automatic idle_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        m_pend = 0; m_err = 0; m_kind = 0; m_rd = 0; m_ra = 0; m_addr = 0;
        fwd_addr0 = 5'd0;
        fwd_addr1 = 5'd0;
        rst_n     = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        reset_dut();

        // ALU write and forward
        fwd_addr0 = 5'd5; fwd_addr1 = 5'd6;
        drive(1, 0, 5, 32'hDEADBEEF, 3, 32'h0, 0, 0);
        cycle();
        check_eq("t1_fwd_direct", fwd_data0, 32'hDEADBEEF);
        idle_cycle();

        // load + address update with three wait cycles
        fwd_addr0 = 5'd7; fwd_addr1 = 5'd2;
        drive(1, 3, 7, 0, 2, 32'h1004, 0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 9, 32'h99, 0, 0, 0, 0);
            cycle();
        end
        drive(0, 0, 0, 0, 0, 0, 1, 32'h55);
        cycle();
        check_eq("t2_both_ports", {30'b0, wen1, wen0}, 32'h3);
        idle_cycle();

        // load + address update to the same register: load data wins
        fwd_addr0 = 5'd4; fwd_addr1 = 5'd4;
        drive(1, 3, 4, 0, 4, 32'h2000, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 1, 32'hA5A5_0004);
        cycle();
        check_eq("t3_collision_fwd", fwd_data1, 32'hA5A5_0004);

        // write to r0 is suppressed; query of r0 never hits
        fwd_addr0 = 5'd0; fwd_addr1 = 5'd0;
        drive(1, 0, 0, 32'h1, 0, 0, 0, 0);
        cycle();

        // spurious rvalid is sticky, and ALU ops still retire
        drive(0, 0, 0, 0, 0, 0, 1, 32'h77);
        cycle();
        fwd_addr0 = 5'd3;
        drive(1, 0, 3, 32'h1234_5678, 0, 0, 0, 0);
        cycle();
        idle_cycle();
        check_eq("t5_err_sticky", {31'b0, err_spurious}, 32'h1);

        // reset during WAIT drops the pending load
        drive(1, 1, 8, 0, 0, 0, 0, 0);
        cycle();
        reset_dut();
        fwd_addr0 = 5'd8;
        drive(0, 0, 0, 0, 0, 0, 1, 32'hBAD);
        cycle();
        check_eq("t6_ready_after_reset", {31'b0, in_ready}, 32'h1);

        // back-to-back ALU ops each produce a write
        for (int i = 1; i <= 4; i++) begin
            fwd_addr0 = 5'(i);
            drive(1, 0, i, 32'h100 + i, 0, 0, 0, 0);
            cycle();
        end

        // randomized traffic
        reset_dut();
        for (int i = 0; i < 2000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            fwd_addr0 = 5'($urandom_range(0, 7));
            fwd_addr1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
            drive($urandom_range(0, 2) != 0, int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 7)), $urandom, int'($urandom_range(0, 7)), $urandom,
                  m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0), $urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
